// File: rtl/alu_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
// Shared types and constants for the ALU sharing arbiter (alu_share_arb) and
// its round-robin picker (alu_rr_picker).
//   alu_arb_state_t : sequencer state (IDLE -> EXEC -> RESP -> IDLE)
//   ALU_W           : operand/result width of the shared ALU
//   ALU_OP_0/1      : encodings of the single ALU op bit
//   PERF_W          : width of each per-requester grant counter
// -----------------------------------------------------------------------------
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_arb_state_t;

  localparam int ALU_W  = 64;
  localparam int PERF_W = 32;

  localparam logic ALU_OP_0 = 1'b0;
  localparam logic ALU_OP_1 = 1'b1;

endpackage : alu_arb_pkg

// File: rtl/alu_rr_picker.sv
// -----------------------------------------------------------------------------
// alu_rr_picker
// Combinational round-robin picker. Searches the request vector starting at
// last_grant+1 and wrapping modulo NREQ; the first set bit wins.
// Ports:
//   req        in  NREQ  request vector
//   last_grant in  GW    index of the most recently served requester
//   gnt        out NREQ  one-hot winner (all zero when nothing requests)
//   gnt_idx    out GW    winner index (0 when nothing requests)
//   any        out 1     at least one request present
// -----------------------------------------------------------------------------
module alu_rr_picker #(
  parameter int NREQ = 2,
  parameter int GW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   last_grant,
  output logic [NREQ-1:0] gnt,
  output logic [GW-1:0]   gnt_idx,
  output logic            any
);

  // Offsets run 1..NREQ so last_grant itself is visited last; that is what
  // makes a continuously requesting set rotate strictly.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = GW'(idx);
      end
    end
  end

endmodule : alu_rr_picker

// File: rtl/alu_share_arb.sv
// -----------------------------------------------------------------------------
// alu_share_arb
// Round-robin arbiter/sequencer sharing one combinational W-bit ALU between
// NREQ requesters. One operation is in flight at a time:
//   IDLE : pick a requester, accept it (req_ready one-hot), register payload
//   EXEC : ALU settles from the registered operands; capture out/eq
//   RESP : present the captured result until the granted requester accepts
//
// Handshakes (both directions): a transfer happens on the rising edge where
// valid and ready are both high for the same requester. Requesters hold valid
// and payload until ready; the arbiter samples payload only on that edge.
// req_ready is combinational from req_valid and asserted only in IDLE.
// rsp_valid is registered-state driven; only rsp_ready[grant] is looked at.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   per-requester request handshake
//   req_a/req_b       packed operands, requester i at [i*W +: W]
//   req_op            per-requester op bit
//   rsp_valid/ready   per-requester response handshake
//   rsp_out/rsp_eq    captured ALU result/eq flag
//   alu_a/alu_b/alu_op registered operands driven into the ALU
//   alu_out/alu_eq    ALU result inputs
//   perf_grants       per-requester 32-bit grant counters, requester i at
//                     [i*32 +: 32]
//
// Build option: define ALU_ARB_PERF_EN to implement saturating grant counters;
// otherwise perf_grants is tied to zero and no counter flops exist.
// -----------------------------------------------------------------------------
module alu_share_arb
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = ALU_W,
  parameter int GW   = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*W-1:0]      req_a,
  input  logic [NREQ*W-1:0]      req_b,
  input  logic [NREQ-1:0]        req_op,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [W-1:0]           rsp_out,
  output logic                   rsp_eq,
  output logic [W-1:0]           alu_a,
  output logic [W-1:0]           alu_b,
  output logic                   alu_op,
  input  logic [W-1:0]           alu_out,
  input  logic                   alu_eq,
  output logic [NREQ*PERF_W-1:0] perf_grants
);

  alu_arb_state_t state;
  alu_arb_state_t state_nxt;

  logic [GW-1:0]   grant;
  logic [GW-1:0]   last_grant;
  logic [NREQ-1:0] pick_gnt;
  logic [GW-1:0]   pick_idx;
  logic            pick_any;
  logic            accept;
  logic            rsp_done;

  alu_rr_picker #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_picker (
    .req        (req_valid),
    .last_grant (last_grant),
    .gnt        (pick_gnt),
    .gnt_idx    (pick_idx),
    .any        (pick_any)
  );

  assign accept   = (state == IDLE) && pick_any;
  assign rsp_done = (state == RESP) && rsp_ready[grant];

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready[grant]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // req_ready is gated by rst_n so it reads zero for the whole reset pulse,
  // even though the reset state is IDLE and valids may be high.
  always_comb begin
    req_ready = '0;
    if ((state == IDLE) && rst_n) req_ready = pick_gnt;
  end

  always_comb begin
    rsp_valid = '0;
    if (state == RESP) rsp_valid[grant] = 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Grant tracking. last_grant resets to NREQ-1 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= '0;
      last_grant <= GW'(NREQ - 1);
    end else begin
      if (accept)   grant      <= pick_idx;
      if (rsp_done) last_grant <= grant;
    end
  end

  // Operand registers only load on an accept, so the ALU inputs stay still
  // while idle and during EXEC/RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= ALU_OP_0;
    end else if (accept) begin
      alu_a  <= req_a[pick_idx*W +: W];
      alu_b  <= req_b[pick_idx*W +: W];
      alu_op <= req_op[pick_idx];
    end
  end

  // Result capture at the end of EXEC; held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_out <= '0;
      rsp_eq  <= 1'b0;
    end else if (state == EXEC) begin
      rsp_out <= alu_out;
      rsp_eq  <= alu_eq;
    end
  end

`ifdef ALU_ARB_PERF_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_perf
    logic [PERF_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (accept && pick_gnt[i] && (cnt != {PERF_W{1'b1}})) begin
        cnt <= cnt + 1'b1;
      end
    end
    assign perf_grants[i*PERF_W +: PERF_W] = cnt;
  end
`else
  assign perf_grants = '0;
`endif

endmodule : alu_share_arb

// File: tb/tb_alu_share_arb.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arb
// Bench for alu_share_arb with a behavioural ALU attached (op 0: A+B,
// op 1: A^B; eq = A==B). Reference model tracks rotation order, expected
// results, last accepted operands and grant counts. Define ALU_ARB_PERF_EN to
// check the counter build.
// -----------------------------------------------------------------------------
module tb_alu_share_arb;

  localparam int NREQ = 2;
  localparam int W    = 64;
  localparam int PW   = 32;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*W-1:0]    req_a;
  logic [NREQ*W-1:0]    req_b;
  logic [NREQ-1:0]      req_op;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [W-1:0]         rsp_out;
  logic                 rsp_eq;
  logic [W-1:0]         alu_a;
  logic [W-1:0]         alu_b;
  logic                 alu_op;
  logic [W-1:0]         alu_out;
  logic                 alu_eq;
  logic [NREQ*PW-1:0]   perf_grants;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int               last_w;
  int unsigned      grant_cnt[NREQ];
  logic [W-1:0]     exp_q[$];
  logic             exp_eq_q[$];
  logic [W-1:0]     last_a;
  logic [W-1:0]     last_b;
  logic             last_op;

  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic op);
    return op ? (a ^ b) : (a + b);
  endfunction

  // behavioural ALU attached to the DUT
  assign alu_out = alu_f(alu_a, alu_b, alu_op);
  assign alu_eq  = (alu_a == alu_b);

  alu_share_arb #(.NREQ(NREQ), .W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_out     (rsp_out),
    .rsp_eq      (rsp_eq),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_out     (alu_out),
    .alu_eq      (alu_eq),
    .perf_grants (perf_grants)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // rotation rule: first valid requester after the last served one
  function automatic int pick(input logic [NREQ-1:0] mask);
    for (int k = 1; k <= NREQ; k++) begin
      if (mask[(last_w + k) % NREQ]) return (last_w + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ*PW-1:0] exp_perf();
    logic [NREQ*PW-1:0] p;
    p = '0;
`ifdef ALU_ARB_PERF_EN
    for (int i = 0; i < NREQ; i++) p[i*PW +: PW] = grant_cnt[i];
`endif
    return p;
  endfunction

  task automatic model_reset();
    last_w = NREQ - 1;
    for (int i = 0; i < NREQ; i++) grant_cnt[i] = 0;
    exp_q.delete();
    exp_eq_q.delete();
    last_a  = '0;
    last_b  = '0;
    last_op = 1'b0;
  endtask

  task automatic randomize_payloads();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = rand64();
      req_b[i*W +: W] = ($urandom_range(0, 3) == 0) ? req_a[i*W +: W] : rand64();
      req_op[i]       = 1'($urandom_range(0, 1));
    end
  endtask

  // driver: one full operation from IDLE; leaves the DUT back in IDLE
  task automatic run_op(input logic [NREQ-1:0] mask, input int stall);
    int              w;
    logic [NREQ-1:0] oh;
    logic [W-1:0]    e_out;
    logic            e_eq;
    req_valid = mask;
    #1;
    w  = pick(mask);
    oh = '0;
    oh[w] = 1'b1;
    chk("req_ready_idle", 64'(req_ready), 64'(oh));
    last_a  = req_a[w*W +: W];
    last_b  = req_b[w*W +: W];
    last_op = req_op[w];
    exp_q.push_back(alu_f(last_a, last_b, last_op));
    exp_eq_q.push_back(last_a == last_b);
    if (grant_cnt[w] != 32'hFFFF_FFFF) grant_cnt[w]++;
    step();  // accept edge
    // winner moves on to its next payload; must not disturb the captured op
    req_a[w*W +: W] = rand64();
    req_b[w*W +: W] = rand64();
    req_op[w]       = ~req_op[w];
    chk("exec_req_ready", 64'(req_ready), 64'(0));
    chk("exec_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("exec_alu_a", alu_a, last_a);
    chk("exec_alu_b", alu_b, last_b);
    chk("exec_alu_op", 64'(alu_op), 64'(last_op));
    step();  // now in RESP
    e_out = exp_q.pop_front();
    e_eq  = exp_eq_q.pop_front();
    rsp_ready = ~oh;  // other requesters' ready must be ignored
    for (int s = 0; s < stall; s++) begin
      chk("stall_rsp_valid", 64'(rsp_valid), 64'(oh));
      chk("stall_rsp_out", rsp_out, e_out);
      chk("stall_rsp_eq", 64'(rsp_eq), 64'(e_eq));
      chk("stall_req_ready", 64'(req_ready), 64'(0));
      step();
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(oh));
    chk("rsp_out", rsp_out, e_out);
    chk("rsp_eq", 64'(rsp_eq), 64'(e_eq));
    rsp_ready = oh;
    step();  // response handshake edge
    last_w = w;
    rsp_ready = '0;
    chk("post_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("perf_grants", perf_grants, exp_perf());
  endtask

  initial begin
    logic [NREQ*PW-1:0] perf_exp;

    // ---- reset state ----
    model_reset();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    rsp_ready = '0;
    randomize_payloads();
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_out", rsp_out, 64'(0));
    chk("rst_alu_a", alu_a, 64'(0));
    chk("rst_alu_b", alu_b, 64'(0));
    chk("rst_perf", perf_grants, 64'(0));
    req_valid = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("idle_req_ready", 64'(req_ready), 64'(0));
    chk("idle_rsp_valid", 64'(rsp_valid), 64'(0));

    // ---- single request, A=B, op=1 ----
    req_a[0 +: W] = 64'h0000_1111_0000_2222;
    req_b[0 +: W] = 64'h0000_1111_0000_2222;
    req_op[0]     = 1'b1;
    run_op(2'b01, 0);
    chk("single_eq_seen", 64'(last_a == last_b), 64'(1));

    // ---- contention: both valid for 6 operations ----
    randomize_payloads();
    for (int i = 0; i < 6; i++) run_op(2'b11, 0);

    // ---- backpressure: 10 cycles stalled ----
    randomize_payloads();
    run_op(2'b11, 10);

    // ---- operand hold, eq=0 ----
    req_a[W +: W] = 64'h0000_0000_FFFF_00FF;
    req_b[W +: W] = 64'h0000_0000_FFFF_FF00;
    req_op[1]     = 1'b0;
    run_op(2'b10, 2);
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      randomize_payloads();
      step();
      chk("hold_alu_a", alu_a, 64'h0000_0000_FFFF_00FF);
      chk("hold_alu_b", alu_b, 64'h0000_0000_FFFF_FF00);
      chk("hold_alu_op", 64'(alu_op), 64'(0));
      chk("hold_rsp_valid", 64'(rsp_valid), 64'(0));
    end

    // ---- randomized traffic ----
    for (int i = 0; i < 20; i++) begin
      logic [NREQ-1:0] m;
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      randomize_payloads();
      run_op(m, $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        req_valid = '0;
        step();
        chk("gap_alu_a", alu_a, last_a);
      end
    end

    // ---- async reset in EXEC ----
    randomize_payloads();
    req_valid = 2'b11;
    step();  // accept; now EXEC
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_req_ready", 64'(req_ready), 64'(0));
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("mid_rst_rsp_out", rsp_out, 64'(0));
    chk("mid_rst_rsp_eq", 64'(rsp_eq), 64'(0));
    chk("mid_rst_alu_a", alu_a, 64'(0));
    chk("mid_rst_alu_b", alu_b, 64'(0));
    chk("mid_rst_alu_op", 64'(alu_op), 64'(0));
    chk("mid_rst_perf", perf_grants, 64'(0));
    req_valid = '0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    end
    randomize_payloads();
    run_op(2'b11, 0);  // model expects requester 0

    // ---- perf: 3 grants to 0, 1 grant to 1 ----
    run_op(2'b01, 0);
    run_op(2'b01, 0);
    run_op(2'b10, 1);
`ifdef ALU_ARB_PERF_EN
    perf_exp = {32'd1, 32'd3};
`else
    perf_exp = '0;
`endif
    chk("perf_final", perf_grants, perf_exp);
    req_valid = '0;
    step();

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_alu_share_arb
